// File: rtl/fft_stream_ctrl_if.sv
// fft_stream_ctrl_if: bundles every non-clock signal of the streaming FFT
// sequencer into one interface.
//   Upstream sample stream : in_valid, in_ready, in_data
//   Downstream bin stream  : out_valid, out_ready, out_data ({re, im}), out_last
//   Status                 : busy, err
//   FFT core pins          : fft_reset, fft_start, fft_load, fft_adr, fft_rd,
//                            fft_wd, fft_done
// The controller connects through the master modport. The environment (source,
// sink and core) connects through the slave modport.
interface fft_stream_ctrl_if #(
  parameter int width = 16,
  parameter int N_2   = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [width-1:0]       in_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [2*width-1:0]     out_data;
  logic                   out_last;

  logic                   busy;
  logic                   err;

  logic                   fft_reset;
  logic                   fft_start;
  logic                   fft_load;
  logic [N_2-1:0]         fft_adr;
  logic [width-1:0]       fft_rd;
  logic [2*width-1:0]     fft_wd;
  logic                   fft_done;

  modport master (
    input  in_valid, in_data, out_ready, fft_wd, fft_done,
    output in_ready, out_valid, out_data, out_last, busy, err,
           fft_reset, fft_start, fft_load, fft_adr, fft_rd
  );

  modport slave (
    output in_valid, in_data, out_ready, fft_wd, fft_done,
    input  in_ready, out_valid, out_data, out_last, busy, err,
           fft_reset, fft_start, fft_load, fft_adr, fft_rd
  );
endinterface

// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl: sequences one frame at a time through the streaming FFT
// core. It collects 2**N_2 samples from upstream and loads them into the core.
// It then pulses start and waits for the core's free-running output burst. It
// captures that burst into a local frame buffer and drains the buffer to a
// back-pressured downstream sink.
//   clk    : single clock, every register updates on posedge
//   reset  : synchronous, active-low
//   bus    : fft_stream_ctrl_if.master (streams, status, core pins)
module fft_stream_ctrl #(
  parameter int width   = 16,
  parameter int N_2     = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  fft_stream_ctrl_if.master bus
);

  localparam int FRAME = 1 << N_2;
  localparam int CW    = N_2 + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic [2:0] {FLUSH, LOAD, START, WAIT, CAPTURE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     k_q, k_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     r_q, r_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [2*width-1:0] frameBuf_q [FRAME];
  logic               bufWrEn;
  logic [N_2-1:0]     bufWrIdx;

  logic inReady, startStb, flushStb, outValid, outLast;
  logic loadEn;

  // Next-state logic. A frame moves through the states as
  // FLUSH -> LOAD -> START -> WAIT -> CAPTURE -> DRAIN -> LOAD. The core's
  // output burst cannot be stalled, so a missing done in CAPTURE or a silent
  // core in WAIT abandons the frame through FLUSH with the sticky error set.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    r_d      = r_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    bufWrEn  = 1'b0;
    bufWrIdx = '0;
    inReady  = 1'b0;
    startStb = 1'b0;
    flushStb = 1'b0;
    outValid = 1'b0;
    outLast  = 1'b0;
    unique case (state_q)
      FLUSH: begin
        flushStb = 1'b1;
        k_d      = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST) state_d = START;
        end
      end
      START: begin
        startStb = 1'b1;
        tmo_d    = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        // The cycle done first rises already carries bin 0.
        if (bus.fft_done) begin
          bufWrEn  = 1'b1;
          bufWrIdx = '0;
          j_d      = CW'(1);
          state_d  = CAPTURE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      CAPTURE: begin
        if (bus.fft_done) begin
          bufWrEn  = 1'b1;
          bufWrIdx = j_q[N_2-1:0];
          j_d      = j_q + 1'b1;
          if (j_q == LAST) begin
            r_d     = '0;
            state_d = DRAIN;
          end
        end else begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end
      end
      DRAIN: begin
        outValid = 1'b1;
        outLast  = (r_q == LAST);
        if (bus.out_ready) begin
          r_d = r_q + 1'b1;
          if (r_q == LAST) begin
            k_d     = '0;
            r_d     = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FLUSH;
      k_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      r_q     <= r_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Frame buffer holds data only. Nothing reads it outside DRAIN, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (bufWrEn) frameBuf_q[bufWrIdx] <= bus.fft_wd;
  end

  // Outputs are qualified by reset so they show their idle values while reset
  // is held. Without this, FLUSH would report busy during reset.
  assign loadEn        = reset & inReady & bus.in_valid;
  assign bus.in_ready  = reset & inReady;
  assign bus.fft_load  = loadEn;
  assign bus.fft_adr   = loadEn ? k_q[N_2-1:0] : '0;
  assign bus.fft_rd    = loadEn ? bus.in_data : '0;
  assign bus.fft_start = reset & startStb;
  assign bus.fft_reset = ~reset | flushStb;
  assign bus.out_valid = reset & outValid;
  assign bus.out_last  = reset & outLast;
  assign bus.out_data  = (reset & outValid) ? frameBuf_q[r_q[N_2-1:0]] : '0;
  assign bus.busy      = reset & ~((state_q == LOAD) && (k_q == '0));
  assign bus.err       = reset & err_q;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// tb_fft_stream_ctrl: directed bench for fft_stream_ctrl with a behavioural
// core model and a scoreboard of expected bins.
module tb_fft_stream_ctrl;

  logic clk;
  logic reset;

  fft_stream_ctrl_if #(.width(16), .N_2(5)) io();

  fft_stream_ctrl #(.width(16), .N_2(5), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] expQ[$];
  logic [15:0] sampTab [32];

  // Core model: latches loaded samples. After start it waits coreLat cycles,
  // then emits coreBurst bins. Bin b is {sample[b], ~sample[31-b]}.
  logic [15:0] coreMem [32];
  bit          coreRun = 1'b0;
  int          coreCnt = 0;
  int          coreLat = 3;
  int          coreBurst = 32;
  logic        strayDone = 1'b0;
  logic        coreDone;
  logic [4:0]  binIdx, mirIdx;

  always @(posedge clk) begin
    if (io.fft_reset) coreRun <= 1'b0;
    if (io.fft_load) coreMem[io.fft_adr] <= io.fft_rd;
    if (io.fft_start) begin
      coreRun <= 1'b1;
      coreCnt <= 0;
    end else if (coreRun) begin
      if (coreCnt >= coreLat + coreBurst) coreRun <= 1'b0;
      else coreCnt <= coreCnt + 1;
    end
  end

  always_comb begin
    coreDone = 1'b0;
    binIdx   = '0;
    mirIdx   = '0;
    if (coreRun && coreCnt >= coreLat && coreCnt < coreLat + coreBurst) begin
      coreDone = 1'b1;
      binIdx   = 5'(coreCnt - coreLat);
      mirIdx   = 5'd31 - binIdx;
    end
  end

  assign io.fft_done = coreDone | strayDone;
  assign io.fft_wd   = coreDone ? {coreMem[binIdx], ~coreMem[mirIdx]} : '0;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds reset low for two cycles while offering a sample, then releases it
  // and checks the single FLUSH cycle.
  task automatic doReset();
    reset = 1'b0;
    io.in_valid = 1'b1;
    io.in_data = 16'h7fff;
    io.out_ready = 1'b0;
    strayDone = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", io.in_ready, 0);
    checkOutput("rst_out_valid", io.out_valid, 0);
    checkOutput("rst_out_last", io.out_last, 0);
    checkOutput("rst_out_data", io.out_data, 0);
    checkOutput("rst_start", io.fft_start, 0);
    checkOutput("rst_load", io.fft_load, 0);
    checkOutput("rst_adr", io.fft_adr, 0);
    checkOutput("rst_rd", io.fft_rd, 0);
    checkOutput("rst_busy", io.busy, 0);
    checkOutput("rst_err", io.err, 0);
    checkOutput("rst_fft_reset", io.fft_reset, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("flush_fft_reset", io.fft_reset, 1);
    checkOutput("flush_in_ready", io.in_ready, 0);
    checkOutput("flush_load", io.fft_load, 0);
    checkOutput("flush_busy", io.busy, 1);
  endtask

  // Pushes one frame of 32 samples, optionally with gaps. Queues the expected
  // bins, then checks the single-cycle start pulse.
  task automatic applyStimulus(input bit gaps, input bit ramp, input bit expectOut);
    int i;
    int cyc;
    bit v;
    logic [15:0] samp;
    i = 0;
    cyc = 0;
    v = 1'b1;
    while (i < 32 && cyc < 200) begin
      @(posedge clk);
      #1;
      v = gaps ? ~v : 1'b1;
      samp = ramp ? 16'(i * 1000 - 15000) : 16'($urandom);
      io.in_valid = v;
      io.in_data = samp;
      @(negedge clk);
      checkOutput("load_in_ready", io.in_ready, 1);
      if (v) begin
        checkOutput("load_strobe", io.fft_load, 1);
        checkOutput("load_adr", io.fft_adr, i);
        checkOutput("load_data", io.fft_rd, samp);
        sampTab[i] = samp;
        i++;
      end else begin
        checkOutput("idle_strobe", io.fft_load, 0);
        checkOutput("idle_data", io.fft_rd, 0);
      end
      cyc++;
    end
    checkOutput("load_count", i, 32);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.in_data = '0;
    if (expectOut) begin
      for (int j = 0; j < 32; j++) expQ.push_back({sampTab[j], ~sampTab[31 - j]});
    end
    @(negedge clk);
    checkOutput("start_pulse", io.fft_start, 1);
    checkOutput("start_in_ready", io.in_ready, 0);
    checkOutput("start_busy", io.busy, 1);
    @(negedge clk);
    checkOutput("start_once", io.fft_start, 0);
  endtask

  // Drives out_ready at the given duty. Every valid cycle compares the bin
  // with the scoreboard head, so a stalled bin must hold steady. The head is
  // popped on each handshake.
  task automatic drainFrame(input int dutyPct, input int nBins);
    int got;
    int cyc;
    logic [31:0] expWord;
    got = 0;
    cyc = 0;
    while (got < nBins && cyc < 1000) begin
      @(posedge clk);
      #1 io.out_ready = ($urandom_range(0, 99) < dutyPct);
      @(negedge clk);
      if (io.out_valid) begin
        expWord = (expQ.size() > 0) ? expQ[0] : 'x;
        checkOutput("out_data", io.out_data, expWord);
        checkOutput("out_last", io.out_last, (got == 31));
        if (io.out_ready) begin
          void'(expQ.pop_front());
          got++;
        end
      end
      cyc++;
    end
    checkOutput("drain_bins", got, nBins);
  endtask

  task automatic checkNextFrameReady();
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("next_in_ready", io.in_ready, 1);
    checkOutput("next_out_valid", io.out_valid, 0);
    checkOutput("next_busy", io.busy, 0);
    checkOutput("frame_err", io.err, 0);
  endtask

  initial begin
    int n;
    bit anyValid;
    reset = 1'b0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;

    $display("[TB] basic ramp frame");
    doReset();
    coreLat = 3;
    coreBurst = 32;
    applyStimulus(1'b0, 1'b1, 1'b1);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!io.out_valid && n < 100);
    checkOutput("first_valid_latency", n, 36);
    drainFrame(100, 32);
    checkNextFrameReady();

    $display("[TB] stray done in LOAD, gapped input, back-pressure");
    @(posedge clk);
    #1 strayDone = 1'b1;
    @(negedge clk);
    checkOutput("stray_in_ready", io.in_ready, 1);
    checkOutput("stray_busy", io.busy, 0);
    @(posedge clk);
    #1 strayDone = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    drainFrame(30, 32);
    checkNextFrameReady();

    $display("[TB] core timeout");
    coreBurst = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    checkOutput("tmo_err_before", io.err, 0);
    checkOutput("tmo_no_flush_yet", io.fft_reset, 0);
    @(negedge clk);
    checkOutput("tmo_err", io.err, 1);
    checkOutput("tmo_flush", io.fft_reset, 1);
    checkOutput("tmo_flush_in_ready", io.in_ready, 0);
    @(negedge clk);
    checkOutput("tmo_reload_ready", io.in_ready, 1);
    checkOutput("tmo_err_sticky", io.err, 1);

    $display("[TB] done drops after 10 bins");
    doReset();
    coreBurst = 10;
    applyStimulus(1'b0, 1'b0, 1'b0);
    anyValid = 1'b0;
    for (int c = 2; c <= 14; c++) begin
      @(negedge clk);
      if (io.out_valid) anyValid = 1'b1;
    end
    checkOutput("drop_err_before", io.err, 0);
    @(negedge clk);
    checkOutput("drop_err", io.err, 1);
    checkOutput("drop_flush", io.fft_reset, 1);
    checkOutput("drop_out_valid", io.out_valid, 0);
    @(negedge clk);
    checkOutput("drop_reload_ready", io.in_ready, 1);
    checkOutput("drop_never_valid", anyValid, 0);

    $display("[TB] reset in the middle of DRAIN");
    doReset();
    coreBurst = 32;
    applyStimulus(1'b0, 1'b1, 1'b1);
    drainFrame(100, 6);
    expQ.delete();
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    drainFrame(100, 32);
    checkNextFrameReady();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/fft_stream_ctrl.md
# fft_stream_ctrl

Sequencing controller that wraps the 32-point streaming FFT core (`fft`) behind ready/valid stream interfaces. It collects 2**N_2 real input samples from an upstream source and loads them into the core with addresses, pulses `start`, and waits for `done`. It then captures the core's free-running output burst into a local frame buffer and drains that buffer to a back-pressured downstream sink. It sits between the sample front end and the spectrum consumer and owns the core's `reset`, `start` and `load` pins.

## Interface
- `width`, 16, sample width; core output word is 2*width ({re, im}).
- `N_2`, 5, log2 of FFT length (frame = 2**N_2 samples).
- `TIMEOUT`, 1024, max cycles from `fft_start` to first `fft_done` before error.

- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `in_data`  in  width  signed real input sample.
- `out_valid`  out  1  output bin valid.
- `out_ready`  in  1  downstream accepts bin.
- `out_data`  out  2*width  {re, im} bin.
- `out_last`  out  1  high with bin 2**N_2-1.
- `busy`  out  1  high in every state except LOAD with zero samples accepted.
- `err`  out  1  sticky error flag; cleared only by reset.
- `fft_reset`  out  1  active-high reset to the core.
- `fft_start`  out  1  one-cycle start pulse to the core.
- `fft_load`  out  1  core load strobe.
- `fft_adr`  out  N_2  core load address.
- `fft_rd`  out  width  core load data.
- `fft_wd`  in  2*width  core output word.
- `fft_done`  in  1  core output valid, one bin per cycle while high.

## Operation
- States: FLUSH, LOAD, START, WAIT, CAPTURE, DRAIN.
- FLUSH (entered on reset, one cycle): `fft_reset`=1. Next state is LOAD.
- LOAD: `in_ready`=1. On `in_valid&&in_ready`: `fft_load`=1, `fft_adr`=sample count `k`, and `fft_rd`=`in_data`, all combinational in the same cycle. Then `k`++. Gaps in `in_valid` are legal; `fft_load`=0 and `fft_rd`=0 on idle cycles. After accepting sample 2**N_2-1, go to START.
- START: `fft_start`=1 for exactly one cycle. Clear the timeout counter. Next state is WAIT.
- WAIT: count cycles. On `fft_done`=1, go to CAPTURE, and that same cycle's `fft_wd` is bin 0. If the counter reaches TIMEOUT, set `err` and go to FLUSH.
- CAPTURE: write `buf[j]`=`fft_wd` on each cycle `fft_done`=1, with `j`=0..2**N_2-1 and bin 0 captured on the WAIT→CAPTURE edge cycle. After `j`=2**N_2-1 is written, go to DRAIN. If `fft_done` drops before all bins are captured, set `err` and go to FLUSH; the frame is discarded.
- DRAIN: `out_valid`=1 and `out_data`=`buf[r]`. `r` advances on `out_valid&&out_ready`. `out_last`=(`r`==2**N_2-1). After the last handshake, go to LOAD with `k`=0, `r`=0.
- Buffer: 2**N_2 × 2*width registers; write-only in CAPTURE, read-only in DRAIN.
- Counters `k`, `j`, `r` are N_2+1 bits. They do not wrap within a frame and are cleared on state entry.
- No arithmetic on data; bins pass bit-exact from `fft_wd` to `out_data`.

## Timing
- Reset values (while `reset`=0): `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `fft_start`=0, `fft_load`=0, `fft_adr`=0, `fft_rd`=0, `busy`=0, `err`=0, `fft_reset`=1. The state register holds FLUSH.
- The first cycle after `reset` goes high is FLUSH, where `fft_reset`=1 and `in_ready`=0. `in_ready`=1 from the second cycle.
- Minimum frame latency with no back-pressure is 2**N_2 load cycles + 1 START cycle + W WAIT cycles, where W is core latency. CAPTURE takes 2**N_2 cycles with bin 0 on the WAIT exit cycle. First `out_valid` appears the cycle after the last capture.
- The core's output cannot be stalled. `out_ready` has no effect outside DRAIN.
- `in_ready`=0 in every state except LOAD; samples offered then are not consumed.
- A `fft_done` pulse seen in LOAD or START is ignored; `err` is not set.
- `reset`=0 in any state, including mid-DRAIN, aborts the frame next edge. `out_valid` drops and no partial `out_last` is issued.

## Test plan
- Basic frame (N_2=5): push 32 ramp samples, `out_ready`=1 → `fft_load` high 32 cycles with `fft_adr` 0..31, then `fft_start` high exactly 1 cycle, then 32 bins equal to the golden FFT vectors, with `out_last` on bin 31 only and `err`=0.
- Input gaps: `in_valid` toggles 1/0 → `fft_load` high only on accepted beats, `fft_adr` contiguous 0..31, same golden output.
- Back-pressure: `out_ready` random 30% duty → all 32 bins delivered in order with `out_data` held stable while stalled. The next frame's `in_ready` rises the cycle after bin 31's handshake.
- Timeout (TIMEOUT=16, core model never asserts `fft_done`) → `err`=1 at cycle 16 after `fft_start`, one FLUSH cycle with `fft_reset`=1, then `in_ready`=1 and `err` still 1.
- Done drop: core model deasserts `fft_done` after 10 bins → `err`=1, no `out_valid`, FLUSH, then back to LOAD.
- Reset mid-DRAIN after bin 5 → `out_valid`=0 and `fft_reset`=1 during reset. One FLUSH cycle follows release; then a fresh frame completes correctly and `err`=0.
